// File: rtl/sram_responder_pkg.sv
// Shared widths, FSM state encoding and counter limits for the SRAM bus responder.
package sram_responder_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_BE_W   = 4;

    localparam logic [3:0] CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_WAIT   = 2'd1,
        ST_RD_DRIVE  = 2'd2,
        ST_WR_ACTIVE = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_word_array.sv
// Word storage for the SRAM responder: one synchronous byte-enabled write port,
// one asynchronous read port.
module sram_word_array
  import sram_responder_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [SRAM_BE_W-1:0]   be_n_i,
  input  logic [DEPTH_LOG2-1:0]  waddr_i,
  input  logic [SRAM_DATA_W-1:0] wdata_i,
  input  logic [DEPTH_LOG2-1:0]  raddr_i,
  output logic [SRAM_DATA_W-1:0] rdata_o
);

  logic [SRAM_DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SRAM_BE_W; b++) begin
        if (!be_n_i[b]) begin
          mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sram_responder.sv
// Cycle-sampled responder for the asynchronous-SRAM bus: programmable read latency,
// minimum write-pulse check, sticky error for short pulses and out-of-range accesses.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    READ_LAT   = 2,
    parameter int    WRITE_MIN  = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ce_n_i,
    input  logic                   oe_n_i,
    input  logic                   we_n_i,
    input  logic [SRAM_BE_W-1:0]   be_n_i,
    input  logic [SRAM_ADDR_W-1:0] addr_i,
    input  logic [SRAM_DATA_W-1:0] data_i,
    output logic [SRAM_DATA_W-1:0] data_o,
    output logic                   data_oe_o,
    output logic                   err_o
);

    localparam logic [3:0] LAT_CNT = 4'(READ_LAT);
    localparam logic [3:0] WR_MIN  = 4'(WRITE_MIN);

    sram_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d, rd_addr;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d, dout_d, mem_rdata, rd_val;
    logic [SRAM_BE_W-1:0]   wbe_n_q, wbe_n_d;
    logic                   doe_d, err_d, mem_we, wr_req;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == CNT_MAX) ? c : c + 4'd1;
    endfunction

    function automatic logic in_range(input logic [SRAM_ADDR_W-1:0] a);
        return (a >> DEPTH_LOG2) == '0;
    endfunction

    // Burst reads follow the live bus address; all other paths use the latched one.
    assign rd_addr = (state_q == ST_RD_DRIVE) ? addr_i : addr_q;
    assign rd_val  = in_range(rd_addr) ? mem_rdata : '0;
    assign wr_req  = !ce_n_i && !we_n_i;

    sram_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_n_i  (wbe_n_q),
        .waddr_i (addr_q[DEPTH_LOG2-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (rd_addr[DEPTH_LOG2-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbe_n_d = wbe_n_q;
        dout_d  = data_o;
        doe_d   = data_oe_o;
        err_d   = err_o;
        mem_we  = 1'b0;
        // A write strobe pre-empts any read phase and stops driving the bus at once.
        if (state_q != ST_WR_ACTIVE && wr_req) begin
            state_d = ST_WR_ACTIVE;
            cnt_d   = 4'd1;
            addr_d  = addr_i;
            wdata_d = data_i;
            wbe_n_d = be_n_i;
            doe_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    doe_d = 1'b0;
                    if (!ce_n_i && !oe_n_i) begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = 4'd1;
                        addr_d  = addr_i;
                    end
                end
                ST_RD_WAIT: begin
                    if (ce_n_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LAT_CNT) begin
                        state_d = ST_RD_DRIVE;
                        doe_d   = 1'b1;
                        dout_d  = rd_val;
                        if (!in_range(addr_q)) err_d = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_RD_DRIVE: begin
                    if (ce_n_i || oe_n_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        doe_d   = 1'b0;
                    end else begin
                        addr_d = addr_i;
                        dout_d = rd_val;
                        if (!in_range(addr_i)) err_d = 1'b1;
                    end
                end
                ST_WR_ACTIVE: begin
                    if (wr_req) begin
                        cnt_d   = sat_inc(cnt_q);
                        wdata_d = data_i;
                        wbe_n_d = be_n_i;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        mem_we  = (cnt_q >= WR_MIN) && in_range(addr_q);
                        if (!mem_we) err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_o    <= '0;
            data_oe_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_o    <= dout_d;
            data_oe_o <= doe_d;
            err_o     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wbe_n_q <= wbe_n_d;
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: transaction-level memory model plus a per-cycle output compare.
module tb_sram_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int READ_LAT   = 2;
    localparam int WRITE_MIN  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
    logic [3:0]  be_n = 4'hF;
    logic [19:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] data_o;
    logic        data_oe_o, err_o;

    always #5 clk = ~clk;

    sram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .READ_LAT   (READ_LAT),
        .WRITE_MIN  (WRITE_MIN),
        .INIT_FILE  ("")
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ce_n_i    (ce_n),
        .oe_n_i    (oe_n),
        .we_n_i    (we_n),
        .be_n_i    (be_n),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (data_o),
        .data_oe_o (data_oe_o),
        .err_o     (err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [int];
    logic        exp_oe = 1'b0, exp_err = 1'b0, chk_en = 1'b0;
    logic [31:0] exp_data = '0;
    logic [31:0] rd_hist [4];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [19:0] a);
        return a[19:DEPTH_LOG2] == '0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [19:0] a);
        if (!in_rng(a)) return 32'h0;
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check1("data_oe", data_oe_o, exp_oe);
            check1("err", err_o, exp_err);
            if (exp_oe) check32("data", data_o, exp_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Present one bus cycle; returns 1 time unit after the edge that sampled it.
    task automatic tick(input logic c, input logic o, input logic w,
                        input logic [3:0] b, input logic [19:0] a, input logic [31:0] d);
        ce_n = c; oe_n = o; we_n = w; be_n = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b1, 1'b1, 4'hF, 20'h0, 32'h0);
            exp_oe = 1'b0;
        end
    endtask

    task automatic do_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] b,
                            input int len, input logic oe_during);
        logic [31:0] w;
        for (int i = 0; i < len; i++) begin
            tick(1'b0, oe_during, 1'b0, b, a, d);
            exp_oe = 1'b0;
        end
        tick(1'b1, 1'b1, 1'b1, 4'hF, a, 32'h0);
        exp_oe = 1'b0;
        if (len >= WRITE_MIN && in_rng(a)) begin
            w = model_rd(a);
            for (int k = 0; k < 4; k++)
                if (!b[k]) w[8*k +: 8] = d[8*k +: 8];
            model_mem[int'(a)] = w;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic do_read(input logic [19:0] a [4], input int n);
        for (int i = 0; i < READ_LAT; i++) begin
            tick(1'b0, 1'b0, 1'b1, 4'hF, a[0], 32'h0);
            exp_oe = 1'b0;
        end
        tick(1'b0, 1'b0, 1'b1, 4'hF, a[0], 32'h0);
        exp_oe = 1'b1;
        exp_data = model_rd(a[0]);
        if (!in_rng(a[0])) exp_err = 1'b1;
        rd_hist[0] = data_o;
        for (int k = 1; k < n; k++) begin
            tick(1'b0, 1'b0, 1'b1, 4'hF, a[k], 32'h0);
            exp_data = model_rd(a[k]);
            rd_hist[k] = data_o;
        end
        tick(1'b0, 1'b1, 1'b1, 4'hF, a[n-1], 32'h0);
        exp_oe = 1'b0;
        idle(1);
    endtask

    task automatic pulse_reset();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        exp_oe = 1'b0;
        exp_err = 1'b0;
        rst = 1'b1;
        #1;
        check1("rst_async_oe", data_oe_o, 1'b0);
        check1("rst_async_err", err_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    logic [19:0] ra [4];

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("reset_oe", data_oe_o, 1'b0);
        check1("reset_err", err_o, 1'b0);
        check32("reset_data", data_o, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Full word write with oe_n also low (write must win), then latency-2 read.
        do_write(20'h00010, 32'hCAFE_BABE, 4'h0, 3, 1'b0);
        ra = '{20'h00010, 20'h0, 20'h0, 20'h0};
        do_read(ra, 1);
        check32("rd_full_word", rd_hist[0], 32'hCAFE_BABE);

        // Single byte lane write.
        do_write(20'h00010, 32'h0000_5500, 4'b1101, 2, 1'b1);
        do_read(ra, 1);
        check32("rd_byte_lane", rd_hist[0], 32'hCAFE_55BE);

        // All lanes disabled: valid pulse, nothing changes, no error.
        do_write(20'h00010, 32'hFFFF_FFFF, 4'hF, 2, 1'b1);
        do_read(ra, 1);
        check32("rd_no_lanes", rd_hist[0], 32'hCAFE_55BE);
        check1("no_lane_err", err_o, 1'b0);

        // Asynchronous reset while driving a read.
        tick(1'b0, 1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        exp_oe = 1'b1;
        exp_data = model_rd(20'h00010);
        #2;
        pulse_reset();
        check32("post_rst_data", data_o, 32'h0);
        do_read(ra, 1);
        check32("rd_after_rst", rd_hist[0], 32'hCAFE_55BE);

        // Short write pulse: dropped, sticky error.
        do_write(20'h00010, 32'h1234_5678, 4'h0, 1, 1'b1);
        idle(3);
        do_read(ra, 1);
        check32("rd_after_short", rd_hist[0], 32'hCAFE_55BE);
        check1("short_err_sticky", err_o, 1'b1);
        pulse_reset();

        // Out-of-range read returns zero and flags an error.
        ra = '{20'h80000, 20'h0, 20'h0, 20'h0};
        do_read(ra, 1);
        check32("rd_oor", rd_hist[0], 32'h0);
        check1("oor_rd_err", err_o, 1'b1);
        pulse_reset();

        // Out-of-range write aliasing index 0x10 must not touch storage.
        do_write(20'h80010, 32'hDEAD_BEEF, 4'h0, 3, 1'b1);
        ra = '{20'h00010, 20'h0, 20'h0, 20'h0};
        do_read(ra, 1);
        check32("rd_after_oor_wr", rd_hist[0], 32'hCAFE_55BE);
        check1("oor_wr_err", err_o, 1'b1);
        pulse_reset();

        // Read request aborted by ce_n before the data phase.
        tick(1'b0, 1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        exp_oe = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 4'hF, 20'h00010, 32'h0);
        exp_oe = 1'b0;
        idle(3);

        // Minimum-length writes, then a held-oe burst.
        do_write(20'h00011, 32'h1111_2222, 4'h0, 2, 1'b1);
        do_write(20'h00012, 32'h3333_4444, 4'h0, 2, 1'b1);
        ra = '{20'h00010, 20'h00011, 20'h00012, 20'h0};
        do_read(ra, 3);
        check32("burst0", rd_hist[0], 32'hCAFE_55BE);
        check32("burst1", rd_hist[1], 32'h1111_2222);
        check32("burst2", rd_hist[2], 32'h3333_4444);
        check1("burst_err", err_o, 1'b0);

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
